// File: rtl/lif_pkg.sv
// Shared constants for the LIF neuron demo board.
// Clock, default baud, ASCII codes and parser state encodings.
package lif_pkg;

    localparam int CLK_HZ = 12_000_000;
    localparam int BAUD   = 115200;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_G  = 8'h47;
    localparam logic [7:0] ASCII_X  = 8'h58;
    localparam logic [7:0] ASCII_T  = 8'h54;
    localparam logic [7:0] ASCII_EQ = 8'h3D;

    localparam logic [2:0] P_IDLE    = 3'd0;
    localparam logic [2:0] P_IDX     = 3'd1;
    localparam logic [2:0] P_EQ      = 3'd2;
    localparam logic [2:0] P_DIG     = 3'd3;
    localparam logic [2:0] P_END     = 3'd4;
    localparam logic [2:0] P_DISCARD = 3'd5;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= 8'h30) && (b <= 8'h39);
    endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer plus centre-sampling FSM.
// A low stop bit pulses frame_err and waits for the line to go high.
module uart_rx
    import lif_pkg::*;
#(
    parameter int CLOCK_FREQ = CLK_HZ,
    parameter int BAUD_RATE  = BAUD
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       valid,
    output logic       frame_err
);

    localparam int CPB  = CLOCK_FREQ / BAUD_RATE;
    localparam int HALF = CPB / 2;
    localparam int CW   = $clog2(CPB + 1);

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    logic [1:0]    sync_q, sync_d;
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shf_q, shf_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    logic          brk_q, brk_d;
    logic          rx_s;

    assign rx_s      = sync_q[1];
    assign data_out  = data_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;

    // Next-state logic for synchronizer and receive FSM
    always_comb begin
        sync_d  = {sync_q[0], rx};
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shf_d   = shf_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        brk_d   = brk_q;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (!rx_s) state_d = RX_START;
            end
            RX_START: begin
                if (cnt_q == CW'(HALF - 1)) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RX_DATA: begin
                if (cnt_q == CW'(CPB - 1)) begin
                    cnt_d = '0;
                    shf_d = {rx_s, shf_q[7:1]};
                    if (bit_q == 3'd7) state_d = RX_STOP;
                    else bit_d = bit_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                if (brk_q) begin
                    if (rx_s) begin
                        brk_d   = 1'b0;
                        state_d = RX_IDLE;
                    end
                end else if (cnt_q == CW'(CPB - 1)) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        valid_d = 1'b1;
                        data_d  = shf_q;
                        state_d = RX_IDLE;
                    end else begin
                        ferr_d = 1'b1;
                        brk_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        endcase
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b11;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shf_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            brk_q   <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shf_q   <= shf_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            brk_q   <= brk_d;
        end
    end

endmodule

// File: rtl/lif_cmd_rx.sv
// Host command receiver: UART bytes to threshold writes and ramp control.
// Parser acts on CR; all command pulses are registered one clk later.
module lif_cmd_rx
    import lif_pkg::*;
#(
    parameter int CLOCK_FREQ = 12_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int MAX_DIGITS = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rx,
    output logic       rx_valid,
    output logic [7:0] rx_byte,
    output logic       frame_err,
    output logic       th_wr,
    output logic [1:0] th_sel,
    output logic [7:0] th_val,
    output logic       start_p,
    output logic       stop_p,
    output logic       cmd_err
);

    localparam int DW = $clog2(MAX_DIGITS + 2);

    logic [2:0]    p_q, p_d;
    logic          cmd_q, cmd_d;
    logic [9:0]    acc_q, acc_d;
    logic [DW-1:0] ndig_q, ndig_d;
    logic [1:0]    idx_q, idx_d;
    logic [1:0]    sel_q, sel_d;
    logic [7:0]    val_q, val_d;
    logic          wr_q, wr_d;
    logic          go_q, go_d;
    logic          halt_q, halt_d;
    logic          err_q, err_d;
    logic [11:0]   acc_n;
    logic [7:0]    b;

    uart_rx #(
        .CLOCK_FREQ (CLOCK_FREQ),
        .BAUD_RATE  (BAUD_RATE)
    ) u_rx (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (uart_rx),
        .data_out  (rx_byte),
        .valid     (rx_valid),
        .frame_err (frame_err)
    );

    assign b       = rx_byte;
    assign acc_n   = 12'(acc_q) * 12'd10 + 12'(b - 8'h30);
    assign th_wr   = wr_q;
    assign th_sel  = sel_q;
    assign th_val  = val_q;
    assign start_p = go_q;
    assign stop_p  = halt_q;
    assign cmd_err = err_q;

    // Line parser; LF is transparent in every state
    always_comb begin
        p_d    = p_q;
        cmd_d  = cmd_q;
        acc_d  = acc_q;
        ndig_d = ndig_q;
        idx_d  = idx_q;
        sel_d  = sel_q;
        val_d  = val_q;
        wr_d   = 1'b0;
        go_d   = 1'b0;
        halt_d = 1'b0;
        err_d  = 1'b0;
        if (frame_err) begin
            p_d = P_DISCARD;
        end else if (rx_valid && b != ASCII_LF) begin
            case (p_q)
                P_IDLE: begin
                    acc_d  = '0;
                    ndig_d = '0;
                    if (b == ASCII_G || b == ASCII_X) begin
                        cmd_d = (b == ASCII_G);
                        p_d   = P_END;
                    end else if (b == ASCII_T) begin
                        p_d = P_IDX;
                    end else if (b != ASCII_CR) begin
                        p_d = P_DISCARD;
                    end
                end
                P_IDX: begin
                    if (b >= 8'h31 && b <= 8'h34) begin
                        idx_d = 2'(b - 8'h31);
                        p_d   = P_EQ;
                    end else if (b == ASCII_CR) begin
                        err_d = 1'b1;
                        p_d   = P_IDLE;
                    end else begin
                        p_d = P_DISCARD;
                    end
                end
                P_EQ: begin
                    if (b == ASCII_EQ) begin
                        p_d = P_DIG;
                    end else if (b == ASCII_CR) begin
                        err_d = 1'b1;
                        p_d   = P_IDLE;
                    end else begin
                        p_d = P_DISCARD;
                    end
                end
                P_DIG: begin
                    if (b == ASCII_CR) begin
                        p_d = P_IDLE;
                        if (ndig_q == '0) begin
                            err_d = 1'b1;
                        end else begin
                            wr_d  = 1'b1;
                            sel_d = idx_q;
                            val_d = acc_q[7:0];
                        end
                    end else if (is_digit(b)) begin
                        if (ndig_q == DW'(MAX_DIGITS) || acc_n > 12'd255) begin
                            p_d = P_DISCARD;
                        end else begin
                            acc_d  = acc_n[9:0];
                            ndig_d = ndig_q + DW'(1);
                        end
                    end else begin
                        p_d = P_DISCARD;
                    end
                end
                P_END: begin
                    if (b == ASCII_CR) begin
                        go_d   = cmd_q;
                        halt_d = !cmd_q;
                        p_d    = P_IDLE;
                    end else begin
                        p_d = P_DISCARD;
                    end
                end
                default: begin
                    if (b == ASCII_CR) begin
                        err_d = 1'b1;
                        p_d   = P_IDLE;
                    end
                end
            endcase
        end
    end

    // Parser state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q    <= P_IDLE;
            cmd_q  <= 1'b0;
            acc_q  <= '0;
            ndig_q <= '0;
            idx_q  <= '0;
            sel_q  <= '0;
            val_q  <= '0;
            wr_q   <= 1'b0;
            go_q   <= 1'b0;
            halt_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            p_q    <= p_d;
            cmd_q  <= cmd_d;
            acc_q  <= acc_d;
            ndig_q <= ndig_d;
            idx_q  <= idx_d;
            sel_q  <= sel_d;
            val_q  <= val_d;
            wr_q   <= wr_d;
            go_q   <= go_d;
            halt_q <= halt_d;
            err_q  <= err_d;
        end
    end

endmodule

// File: tb/tb_lif_cmd_rx.sv
// Directed bench for lif_cmd_rx: serial frames in, pulse counts out.
// Expected counts and values are hand-derived per test step.
module tb_lif_cmd_rx;

    localparam int CPB = 104;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       uart_rx = 1'b1;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       frame_err;
    logic       th_wr;
    logic [1:0] th_sel;
    logic [7:0] th_val;
    logic       start_p;
    logic       stop_p;
    logic       cmd_err;

    int nvec = 0;
    int nerr = 0;

    int n_rxv = 0, n_fe = 0, n_wr = 0, n_go = 0, n_st = 0, n_ce = 0;
    int b_rxv, b_fe, b_wr, b_go, b_st, b_ce;
    int bad_tm = 0;
    logic prev_cr = 1'b0;

    always #5 clk = ~clk;

    lif_cmd_rx dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .uart_rx   (uart_rx),
        .rx_valid  (rx_valid),
        .rx_byte   (rx_byte),
        .frame_err (frame_err),
        .th_wr     (th_wr),
        .th_sel    (th_sel),
        .th_val    (th_val),
        .start_p   (start_p),
        .stop_p    (stop_p),
        .cmd_err   (cmd_err)
    );

    // Pulse counters and CR-to-pulse latency monitor
    always @(negedge clk) begin
        if (rx_valid) n_rxv++;
        if (frame_err) n_fe++;
        if (th_wr) n_wr++;
        if (start_p) n_go++;
        if (stop_p) n_st++;
        if (cmd_err) n_ce++;
        if ((th_wr || start_p || stop_p || cmd_err) && !prev_cr) bad_tm++;
        prev_cr = rx_valid && (rx_byte == 8'h0D);
    end

    task automatic chk(input string tag, input int obs, input int exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic snap();
        b_rxv = n_rxv; b_fe = n_fe; b_wr = n_wr;
        b_go = n_go; b_st = n_st; b_ce = n_ce;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input logic stopb);
        uart_rx = 1'b0;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            idle(CPB);
        end
        uart_rx = stopb;
        idle(CPB);
        uart_rx = 1'b1;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i], 1'b1);
        idle(20);
    endtask

    initial begin
        idle(5);
        chk("rst_rxv", int'(rx_valid), 0);
        chk("rst_byte", int'(rx_byte), 0);
        chk("rst_sel", int'(th_sel), 0);
        chk("rst_val", int'(th_val), 0);
        rst_n = 1'b1;
        idle(50);

        // 1: simple threshold write
        snap();
        send_str("T2=128\r");
        chk("t1_rxv", n_rxv - b_rxv, 7);
        chk("t1_wr", n_wr - b_wr, 1);
        chk("t1_sel", int'(th_sel), 1);
        chk("t1_val", int'(th_val), 128);
        chk("t1_ce", n_ce - b_ce, 0);
        chk("t1_byte", int'(rx_byte), 13);

        // 2: start / stop with trailing LF
        snap();
        send_str("G\r\n");
        chk("t2_go", n_go - b_go, 1);
        chk("t2_st0", n_st - b_st, 0);
        send_str("X\r");
        chk("t2_st", n_st - b_st, 1);
        chk("t2_go1", n_go - b_go, 1);
        chk("t2_ce", n_ce - b_ce, 0);

        // 3: malformed threshold lines
        snap();
        send_str("T3=300\r");
        send_str("T5=10\r");
        send_str("T1=\r");
        send_str("T1=0012\r");
        chk("t3_ce", n_ce - b_ce, 4);
        chk("t3_wr", n_wr - b_wr, 0);
        chk("t3_val", int'(th_val), 128);

        // 4: framing error then recovery
        snap();
        send(8'h41, 1'b0);
        idle(30);
        chk("t4_fe", n_fe - b_fe, 1);
        chk("t4_rxv", n_rxv - b_rxv, 0);
        send_str("G\r");
        chk("t4_ce", n_ce - b_ce, 1);
        chk("t4_go0", n_go - b_go, 0);
        send_str("G\r");
        chk("t4_go", n_go - b_go, 1);
        chk("t4_ce1", n_ce - b_ce, 1);

        // 5: short glitch on idle line
        snap();
        uart_rx = 1'b0;
        idle(20);
        uart_rx = 1'b1;
        idle(3 * CPB);
        chk("t5_rxv", n_rxv - b_rxv, 0);
        chk("t5_fe", n_fe - b_fe, 0);
        send_str("T4=255\r");
        chk("t5_wr", n_wr - b_wr, 1);
        chk("t5_sel", int'(th_sel), 3);
        chk("t5_val", int'(th_val), 255);
        chk("t5_ce", n_ce - b_ce, 0);

        // 6: reset during data bit 4 of 'T'
        uart_rx = 1'b0;
        idle(CPB);
        for (int i = 0; i < 4; i++) begin
            uart_rx = (8'h54 >> i) & 1'b1;
            idle(CPB);
        end
        uart_rx = 1'b1;
        idle(50);
        rst_n = 1'b0;
        idle(10);
        chk("t6_sel", int'(th_sel), 0);
        chk("t6_val", int'(th_val), 0);
        chk("t6_byte", int'(rx_byte), 0);
        chk("t6_wrp", int'(th_wr), 0);
        rst_n = 1'b1;
        snap();
        idle(12 * CPB);
        chk("t6_quiet", (n_rxv - b_rxv) + (n_fe - b_fe) + (n_ce - b_ce), 0);
        send_str("T1=0\r");
        chk("t6_wr", n_wr - b_wr, 1);
        chk("t6_sel1", int'(th_sel), 0);
        chk("t6_val1", int'(th_val), 0);
        chk("t6_ce", n_ce - b_ce, 0);

        chk("latency", bad_tm, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
